reg_write_arbiter: RTL

//  - Shares the write port of a bank of NREG enable-registers (WIDTH bits each) among NREQ requesters.
//  - Arbitration is round-robin; each accepted request produces exactly one single-cycle register write.
//  - Drives one-hot wr_en straight into the register wrenable inputs, with one common wr_data bus.
//  - Sits between audio control sources (UART cfg, sequencer, UI) and the shared parameter registers.

---
 rtl/reg_arb_pkg.sv | 14 +
 rtl/rr_pick.sv | 32 +++
 rtl/reg_write_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/reg_arb_pkg.sv
// Shared types and helpers for reg_write_arbiter: FSM state encoding and address-width sizing.
package reg_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    // $clog2 clamped to at least 1 so single-entry ranges still get a real index bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req_vec at or after ptr, wrapping at N.
module rr_pick
    import reg_arb_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned IW = clog2_min1(N)
) (
    input  logic [N-1:0]  req_vec,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt_onehot,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    always_comb begin
        logic [IW-1:0] idx;
        logic          found;
        gnt_idx = '0;
        idx     = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = IW'((32'(ptr) + i) % N);
            if (!found && req_vec[idx]) begin
                found   = 1'b1;
                gnt_idx = idx;
            end
        end
        any        = |req_vec;
        gnt_onehot = any ? (N'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one register-bank write port among NREQ requesters.
// Define REG_ARB_ADDR_CHECK_EN to add the err output flagging out-of-range addresses.
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREG  = 8,
    localparam int unsigned AW = clog2_min1(NREG),
    localparam int unsigned IW = clog2_min1(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*AW-1:0]    req_addr,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       ack,
    output logic [NREG-1:0]       wr_en,
    output logic [WIDTH-1:0]      wr_data,
    output logic                  busy
`ifdef REG_ARB_ADDR_CHECK_EN
    ,
    output logic                  err
`endif
);

    state_e            state_q, state_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]     win_q, win_d;
    logic [NREQ-1:0]   last_ack_q, last_ack_d;
    logic [NREQ-1:0]   ack_d;
    logic [NREG-1:0]   wr_en_d;
    logic [WIDTH-1:0]  wr_data_d;
    logic              busy_d;
    logic              err_d;

    logic [NREQ-1:0]   eligible;
    logic [NREQ-1:0]   gnt_onehot;
    logic [IW-1:0]     gnt_idx;
    logic              gnt_any;
    logic [AW-1:0]     sel_addr;
    logic [WIDTH-1:0]  sel_data;
    logic              addr_ok;

    // The requester acked last is masked for one IDLE cycle so it can drop req cleanly.
    assign eligible = req & ~last_ack_q;
    assign sel_addr = req_addr[32'(gnt_idx) * AW +: AW];
    assign sel_data = req_data[32'(gnt_idx) * WIDTH +: WIDTH];
    assign addr_ok  = 32'(sel_addr) < NREG;

    rr_pick #(
        .N (NREQ)
    ) u_pick (
        .req_vec    (eligible),
        .ptr        (rr_ptr_q),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any        (gnt_any)
    );

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        win_d      = win_q;
        last_ack_d = last_ack_q;
        ack_d      = '0;
        wr_en_d    = '0;
        wr_data_d  = '0;
        busy_d     = 1'b0;
        err_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                last_ack_d = '0;
                if (gnt_any) begin
                    // Outputs are registered here so they are visible during ISSUE.
                    state_d   = ISSUE;
                    win_d     = gnt_idx;
                    ack_d     = gnt_onehot;
                    wr_data_d = sel_data;
                    busy_d    = 1'b1;
                    err_d     = !addr_ok;
                    if (addr_ok) begin
                        wr_en_d = NREG'(1) << sel_addr;
                    end
                end
            end
            ISSUE: begin
                state_d    = IDLE;
                last_ack_d = NREQ'(1) << win_q;
                if (32'(win_q) == NREQ - 1) begin
                    rr_ptr_d = '0;
                end else begin
                    rr_ptr_d = win_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            win_q      <= '0;
            last_ack_q <= '0;
            ack        <= '0;
            wr_en      <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            win_q      <= win_d;
            last_ack_q <= last_ack_d;
            ack        <= ack_d;
            wr_en      <= wr_en_d;
            wr_data    <= wr_data_d;
            busy       <= busy_d;
        end
    end

`ifdef REG_ARB_ADDR_CHECK_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else begin
            err <= err_d;
        end
    end
`else
    logic unused_err;
    assign unused_err = err_d;
`endif

endmodule
